pipe_stage_buffer: RTL and testbench

- Parametrised successor to the fixed pipeline-stage buffer between CPU stages (decode/execute/memory/writeback).
- Carries CHANNELS fields of WIDTH bits each, with a valid/ready handshake, a 2-entry skid so back-pressure is fully registered, stage flush, and NOP injection.
- Lets the CPU stall and squash stages, e.g. on taken branches and load-use hazards, without combinational ready paths crossing stages.

---
 rtl/pipe_stage_buffer.sv | 130 +++++++++++++
 tb/tb_pipe_stage_buffer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buffer.sv
// Two-entry pipeline-stage buffer (main + skid) with fully registered back-pressure,
// stage flush and NOP injection on channel 0 whenever the stage is empty.
module pipe_stage_buffer #(
    parameter int              WIDTH    = 32,
    parameter int              CHANNELS = 6,
    parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(32'h00000013)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [1:0]                count
);
    localparam int DW = CHANNELS * WIDTH;

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MAIN_HOLD,
        MAIN_IN,
        MAIN_SKID,
        MAIN_NOP
    } main_sel_t;

    state_t          r_state;
    state_t          w_state_next;
    main_sel_t       w_main_sel;
    logic            w_skid_load;
    logic            r_in_ready;
    logic [DW-1:0]   r_main;
    logic [DW-1:0]   r_skid;
    logic [DW-1:0]   w_nop_pattern;
    logic            w_accept;
    logic            w_pop;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_nop
            if (gi == 0) begin : g_ch0
                assign w_nop_pattern[gi*WIDTH +: WIDTH] = NOP_WORD;
            end else begin : g_chn
                assign w_nop_pattern[gi*WIDTH +: WIDTH] = '0;
            end
        end
    endgenerate

    // A word offered during flush is dropped even though in_ready may be high.
    assign w_accept = in_valid & r_in_ready & ~flush;
    assign w_pop    = out_valid & out_ready;

    always_comb begin
        w_state_next = r_state;
        w_main_sel   = MAIN_HOLD;
        w_skid_load  = 1'b0;
        if (flush) begin
            w_state_next = S_EMPTY;
            w_main_sel   = MAIN_NOP;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state_next = S_ONE;
                        w_main_sel   = MAIN_IN;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_pop) begin
                        w_main_sel   = MAIN_IN;
                    end else if (w_accept) begin
                        w_state_next = S_FULL;
                        w_skid_load  = 1'b1;
                    end else if (w_pop) begin
                        w_state_next = S_EMPTY;
                        w_main_sel   = MAIN_NOP;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        w_state_next = S_ONE;
                        w_main_sel   = MAIN_SKID;
                    end
                end
                default: begin
                    w_state_next = S_EMPTY;
                    w_main_sel   = MAIN_NOP;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
            r_main     <= w_nop_pattern;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != S_FULL);
            case (w_main_sel)
                MAIN_IN:   r_main <= in_data;
                MAIN_SKID: r_main <= r_skid;
                MAIN_NOP:  r_main <= w_nop_pattern;
                default:   r_main <= r_main;
            endcase
        end
    end

    // Skid contents are only meaningful while the stage is FULL, so no reset.
    always_ff @(posedge clk) begin
        if (w_skid_load && !reset) begin
            r_skid <= in_data;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != S_EMPTY);
    assign out_data  = r_main;
    assign count     = r_state;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: a 6x32 instance and a 1x16 instance share
// the same control stimulus; a vector table plus an ordering sequence under back-pressure.
module tb_pipe_stage_buffer;
    localparam int W  = 32;
    localparam int C  = 6;
    localparam int DW = W * C;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic          in_ready, out_valid;
    logic [1:0]    count;
    logic [15:0]   in_data_b, out_data_b;
    logic          in_ready_b, out_valid_b;
    logic [1:0]    count_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_buffer #(.WIDTH(W), .CHANNELS(C), .NOP_WORD(32'h00000013)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .count(count)
    );

    pipe_stage_buffer #(.WIDTH(16), .CHANNELS(1), .NOP_WORD(16'h0013)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data_b), .flush(flush), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .count(count_b)
    );

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [31:0] tag;
        logic        e_ov;
        logic        e_ir;
        logic [1:0]  e_cnt;
        logic [31:0] e_tag;
    } vec_t;

    vec_t vecs[32];
    int   nvec = 0;

    // Channel 0 carries the tag; channel k carries tag + 0x1111*k.
    function automatic logic [DW-1:0] make_word(input logic [31:0] tag);
        logic [DW-1:0] w;
        for (int k = 0; k < C; k++) w[k*W +: W] = tag + 32'(k) * 32'h1111;
        return w;
    endfunction

    function automatic logic [DW-1:0] nop_pat();
        logic [DW-1:0] w;
        w = '0;
        w[31:0] = 32'h00000013;
        return w;
    endfunction

    task automatic add(input logic rst, input logic fl, input logic iv, input logic ordy,
                       input logic [31:0] tag, input logic e_ov, input logic e_ir,
                       input logic [1:0] e_cnt, input logic [31:0] e_tag);
        vecs[nvec] = '{rst, fl, iv, ordy, tag, e_ov, e_ir, e_cnt, e_tag};
        nvec++;
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic iv, input logic ordy,
                         input logic [31:0] tag);
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        in_data   = make_word(tag);
        in_data_b = tag[15:0];
    endtask

    initial begin
        logic [DW-1:0] exp_d;
        logic [15:0]   exp_b;
        logic [15:0]   pat;
        int            sent, rcvd, cyc;
        logic          acc, pop;

        //   rst fl iv ordy tag          ov ir cnt e_tag
        add(1, 0, 1, 0, 32'h55,     0, 1, 0, 0);       // reset with in_valid high
        add(1, 0, 1, 0, 32'h55,     0, 1, 0, 0);
        add(0, 0, 0, 0, 32'h0,      0, 1, 0, 0);
        add(0, 0, 1, 1, 32'h100,    1, 1, 1, 32'h100); // streaming
        add(0, 0, 1, 1, 32'h104,    1, 1, 1, 32'h104);
        add(0, 0, 1, 1, 32'h108,    1, 1, 1, 32'h108);
        add(0, 0, 0, 1, 32'h0,      0, 1, 0, 0);
        add(0, 0, 1, 0, 32'hA0,     1, 1, 1, 32'hA0);  // stall fill
        add(0, 0, 1, 0, 32'hB0,     1, 0, 2, 32'hA0);
        add(0, 0, 1, 0, 32'hC0,     1, 0, 2, 32'hA0);  // C refused, head stable
        add(0, 0, 1, 1, 32'hC0,     1, 1, 1, 32'hB0);
        add(0, 0, 1, 1, 32'hC0,     1, 1, 1, 32'hC0);
        add(0, 0, 0, 1, 32'h0,      0, 1, 0, 0);
        add(0, 0, 1, 0, 32'hA1,     1, 1, 1, 32'hA1);  // accept+pop in ONE
        add(0, 0, 1, 1, 32'hB1,     1, 1, 1, 32'hB1);
        add(0, 0, 1, 0, 32'hC1,     1, 0, 2, 32'hB1);
        add(0, 1, 1, 0, 32'hD0,     0, 1, 0, 0);       // flush while FULL
        add(0, 0, 0, 1, 32'h0,      0, 1, 0, 0);
        add(0, 1, 1, 1, 32'hD1,     0, 1, 0, 0);       // flush drops offered word
        add(0, 0, 0, 1, 32'h0,      0, 1, 0, 0);
        add(0, 0, 1, 0, 32'hE0,     1, 1, 1, 32'hE0);
        add(0, 0, 1, 0, 32'hE4,     1, 0, 2, 32'hE0);
        add(1, 0, 1, 0, 32'hE8,     0, 1, 0, 0);       // reset mid-stream
        add(0, 0, 0, 1, 32'h0,      0, 1, 0, 0);

        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].tag);
            @(posedge clk);
            #1;
            exp_d = vecs[i].e_ov ? make_word(vecs[i].e_tag) : nop_pat();
            exp_b = vecs[i].e_ov ? vecs[i].e_tag[15:0] : 16'h0013;
            check($sformatf("v%0d out_valid", i), DW'(out_valid), DW'(vecs[i].e_ov));
            check($sformatf("v%0d in_ready", i),  DW'(in_ready),  DW'(vecs[i].e_ir));
            check($sformatf("v%0d count", i),     DW'(count),     DW'(vecs[i].e_cnt));
            check($sformatf("v%0d out_data", i),  out_data,       exp_d);
            check($sformatf("v%0d b_out_valid", i), DW'(out_valid_b), DW'(vecs[i].e_ov));
            check($sformatf("v%0d b_in_ready", i),  DW'(in_ready_b),  DW'(vecs[i].e_ir));
            check($sformatf("v%0d b_count", i),     DW'(count_b),     DW'(vecs[i].e_cnt));
            check($sformatf("v%0d b_out_data", i),  DW'(out_data_b),  DW'(exp_b));
            $display("vec %0d: rst=%0b fl=%0b iv=%0b ordy=%0b tag=%0h -> ov=%0b ir=%0b cnt=%0d ch0=%0h",
                     i, vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].tag,
                     out_valid, in_ready, count, out_data[31:0]);
        end

        // Ordering under irregular back-pressure: 8 words must pop in order, once each.
        pat  = 16'b0011_0101_1001_1100;
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 8 && cyc < 80) begin
            @(negedge clk);
            drive(1'b0, 1'b0, (sent < 8), pat[cyc % 16], 32'h300 + 32'(sent) * 4);
            #1;
            acc = in_valid & in_ready;
            pop = out_valid & out_ready;
            if (pop) begin
                check($sformatf("seq pop%0d data", rcvd), out_data, make_word(32'h300 + 32'(rcvd) * 4));
                check($sformatf("seq pop%0d b_data", rcvd), DW'(out_data_b),
                      DW'(16'h300 + 16'(rcvd) * 16'd4));
                $display("seq pop %0d: ch0=%0h count=%0d", rcvd, out_data[31:0], count);
                rcvd++;
            end
            if (acc) sent++;
            cyc++;
        end
        check("seq words received", DW'(rcvd), DW'(8));
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        @(posedge clk);
        #1;
        check("seq final count", DW'(count), DW'(0));
        check("seq final out_data", out_data, nop_pat());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
